// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes, NOP word and fetch FSM state encoding
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [31:0] INST_NOP = 32'h0000_0000;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - IF-stage bus: imem port, redirect/hazard inputs, IF/ID outputs
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface inst_fetch_unit_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        halt_req;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;
`endif

   modport master (
      input  imem_rdata, stall, branch_taken, branch_target, jump, jump_target, halt_req,
`ifdef FETCH_PERF_EN
      output perf_fetch_cnt, perf_bubble_cnt,
`endif
      output imem_addr, if_id_inst, if_id_pc4, if_id_valid, halted
   );

   modport slave (
      output imem_rdata, stall, branch_taken, branch_target, jump, jump_target, halt_req,
`ifdef FETCH_PERF_EN
      input  perf_fetch_cnt, perf_bubble_cnt,
`endif
      input  imem_addr, if_id_inst, if_id_pc4, if_id_valid, halted
   );
endinterface

// File: rtl/fetch_halt_fsm.sv
// rtl/fetch_halt_fsm.sv - RUN/DRAIN/HALTED sequencer with drain counter and sticky halted flag
module fetch_halt_fsm
   import mips_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic halt_accept_i,
   output logic run_o,
   output logic halted_o
);

   localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       halted_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (halt_accept_i) begin
               state_d = ST_DRAIN;
               cnt_d   = CNT_INIT;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == 4'd0) state_d = ST_HALTED;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   // halted rises on the same edge that enters HALTED and only Rst clears it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_RUN;
         cnt_q    <= 4'd0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_q | (state_d == ST_HALTED);
      end
   end

   assign run_o    = (state_q == ST_RUN);
   assign halted_o = halted_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - MIPS IF stage: PC, IF/ID register, redirect, stall and halt drain
// Optional perf counters enabled by FETCH_PERF_EN.
module inst_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET     = 32'h0000_0000,
   parameter int          DRAIN_CYCLES = 3
) (
   input  logic              Clk,
   input  logic              Rst,
   inst_fetch_unit_if.master bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_plus4;
   logic        run, halted, halt_accept, do_fetch;

   assign pc_plus4    = pc_q + 32'd4;
   // a taken branch squashes the younger halt in the same cycle
   assign halt_accept = run & ~bus.branch_taken & bus.halt_req;

   fetch_halt_fsm #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_halt_fsm (
      .clk_i        (Clk),
      .rst_i        (Rst),
      .halt_accept_i(halt_accept),
      .run_o        (run),
      .halted_o     (halted)
   );

   always_comb begin
      pc_d     = pc_q;
      inst_d   = INST_NOP;
      pc4_d    = 32'd0;
      valid_d  = 1'b0;
      do_fetch = 1'b0;
      if (run) begin
         if (bus.branch_taken) begin
            pc_d = bus.branch_target;
         end else if (bus.halt_req) begin
            pc_d = pc_q;
         end else if (bus.jump) begin
            pc_d = bus.jump_target;
         end else if (bus.stall) begin
            inst_d  = inst_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
         end else begin
            do_fetch = 1'b1;
            pc_d     = pc_plus4;
            inst_d   = bus.imem_rdata;
            pc4_d    = pc_plus4;
            valid_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pc_q    <= PC_RESET;
         inst_q  <= INST_NOP;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.if_id_inst  = inst_q;
   assign bus.if_id_pc4   = pc4_q;
   assign bus.if_id_valid = valid_q;
   assign bus.halted      = halted;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;

   // every RUN cycle is either a fetch or a bubble (stall, flush or halt accept)
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         fetch_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else if (run) begin
         if (do_fetch) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
         else          bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign bus.perf_fetch_cnt  = fetch_cnt_q;
   assign bus.perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit against a behavioural model
module tb_inst_fetch_unit;

   localparam int DC = 3;

   logic Clk = 1'b0;
   logic Rst;

   inst_fetch_unit_if bus ();

   inst_fetch_unit #(.PC_RESET(32'h0), .DRAIN_CYCLES(DC)) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   bit mem_const = 1'b1;

   function automatic logic [31:0] mem_fn(input logic [31:0] a, input bit c);
      if (c) return 32'h2008_0005;
      return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1234} | 32'h1;
   endfunction

   always_comb bus.imem_rdata = mem_fn(bus.imem_addr, mem_const);

   // behavioural model: architectural PC, IF/ID contents, halt progress in edges
   logic [31:0] m_pc, m_inst, m_pc4, m_fetch, m_bubble;
   logic        m_valid, m_halted;
   bit          m_halt_seen;
   int          m_after;

   task automatic model_reset();
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      m_halt_seen = 1'b0; m_after = 0; m_fetch = 32'h0; m_bubble = 32'h0;
   endtask

   task automatic model_flush();
      m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_bubble = m_bubble + 1;
   endtask

   task automatic model_edge();
      if (m_halt_seen) begin
         m_after = m_after + 1;
         if (m_after >= DC) m_halted = 1'b1;
      end else if (bus.branch_taken) begin
         m_pc = bus.branch_target; model_flush();
      end else if (bus.halt_req) begin
         m_halt_seen = 1'b1; m_after = 0; model_flush();
      end else if (bus.jump) begin
         m_pc = bus.jump_target; model_flush();
      end else if (bus.stall) begin
         m_bubble = m_bubble + 1;
      end else begin
         m_inst = mem_fn(m_pc, mem_const); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
         m_valid = 1'b1; m_fetch = m_fetch + 1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".imem_addr"}, bus.imem_addr, m_pc);
      check({tag, ".if_id_inst"}, bus.if_id_inst, m_inst);
      check({tag, ".if_id_pc4"}, bus.if_id_pc4, m_pc4);
      check({tag, ".if_id_valid"}, {31'h0, bus.if_id_valid}, {31'h0, m_valid});
      check({tag, ".halted"}, {31'h0, bus.halted}, {31'h0, m_halted});
`ifdef FETCH_PERF_EN
      check({tag, ".perf_fetch"}, bus.perf_fetch_cnt, m_fetch);
      check({tag, ".perf_bubble"}, bus.perf_bubble_cnt, m_bubble);
`endif
   endtask

   task automatic set_in(input bit st, input bit br, input logic [31:0] bt,
                         input bit jp, input logic [31:0] jt, input bit hr);
      bus.stall = st; bus.branch_taken = br; bus.branch_target = bt;
      bus.jump = jp; bus.jump_target = jt; bus.halt_req = hr;
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge Clk);
      @(negedge Clk);
      check_all(tag);
   endtask

   task automatic sync_reset();
      Rst = 1'b1;
      model_reset();
      @(negedge Clk);
      check_all("reset");
      Rst = 1'b0;
   endtask

   initial begin
      Rst = 1'b1;
      set_in(0, 0, 32'h0, 0, 32'h0, 0);
      model_reset();
      @(negedge Clk);
      check_all("reset");
      Rst = 1'b0;

      // sequential fetch of a constant addi word
      step("fetch0");
      check("fetch0.inst_addi", bus.if_id_inst, 32'h2008_0005);
      step("fetch1");
      check("fetch1.addr8", bus.imem_addr, 32'h8);

      // two stall cycles at PC=8, then resume
      set_in(1, 0, 32'h0, 0, 32'h0, 0);
      step("stall0");
      step("stall1");
      set_in(0, 0, 32'h0, 0, 32'h0, 0);
      step("resume");
      check("resume.addr12", bus.imem_addr, 32'hC);

      // branch beats jump and stall
      set_in(1, 1, 32'h40, 1, 32'h80, 0);
      step("br_jmp_stall");
      check("br_jmp_stall.addr", bus.imem_addr, 32'h40);
      set_in(0, 0, 32'h0, 0, 32'h0, 0);

      // randomized hazards and redirects (no halt)
      mem_const = 1'b0;
      for (int i = 0; i < 150; i++) begin
         set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom,
                $urandom_range(0, 9) == 0, $urandom, 0);
         step("random");
      end
      set_in(0, 0, 32'h0, 0, 32'h0, 0);

      // PC wrap after jump to the top of the address space
      sync_reset();
      set_in(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
      step("wrap_jump");
      set_in(0, 0, 32'h0, 0, 32'h0, 0);
      step("wrap_fetch");
      check("wrap.addr0", bus.imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
      check("wrap.perf_fetch1", bus.perf_fetch_cnt, 32'd1);
      check("wrap.perf_bubble1", bus.perf_bubble_cnt, 32'd1);
`endif

      // halt at PC=0x10, drain, ignore everything while halted
      sync_reset();
      for (int i = 0; i < 4; i++) step("pre_halt");
      check("pre_halt.addr", bus.imem_addr, 32'h10);
      set_in(0, 0, 32'h0, 0, 32'h0, 1);
      step("halt_accept");
      for (int i = 0; i < 6; i++) begin
         set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
         step("drain_halted");
      end
      set_in(0, 1, 32'h200, 0, 32'h0, 0);
      step("halted_branch");
      check("halted.flag", {31'h0, bus.halted}, 32'h1);
      check("halted.pc", bus.imem_addr, 32'h10);
      set_in(0, 0, 32'h0, 0, 32'h0, 0);
      #2 Rst = 1'b1;
      #1 model_reset();
      check_all("halted_async_rst");
      @(negedge Clk);
      Rst = 1'b0;

      // asynchronous reset in the middle of DRAIN
      step("md_fetch0");
      step("md_fetch1");
      set_in(0, 0, 32'h0, 0, 32'h0, 1);
      step("md_halt");
      set_in(0, 0, 32'h0, 0, 32'h0, 0);
      step("md_drain");
      #2 Rst = 1'b1;
      #1 model_reset();
      check_all("drain_async_rst");
      @(negedge Clk);
      Rst = 1'b0;
      step("after_rst_fetch");
      check("after_rst.addr4", bus.imem_addr, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
